// File: rtl/sam_tx_if.sv
// Message-source handshake bundle for the SAM transmitter.
// The source presents a byte with valid; the transmitter answers with ready.
interface sam_tx_if;
  logic [7:0] msg_data;
  logic       msg_valid;
  logic       msg_ready;

  modport master (
    output msg_data,
    output msg_valid,
    input  msg_ready
  );

  modport slave (
    input  msg_data,
    input  msg_valid,
    output msg_ready
  );
endinterface

// File: rtl/sam_tx.sv
// SAM single-wire link transmitter.
// Shifts a 20-bit configuration word {n, d, N} with mode high, then sends
// message words MSB first with each bit repeated N times, followed by a
// d-cycle idle gap.
module sam_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_start,
  input  logic [3:0] cfg_n,
  input  logic [7:0] cfg_d,
  input  logic [7:0] cfg_N,
  sam_tx_if.slave    msg,
  output logic       str,
  output logic       mode,
  output logic       frame,
  output logic       configured,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_READY = 3'd2,
    S_DATA  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [18:0] r_shift;
  logic [4:0]  r_cfg_cnt;
  logic [7:0]  r_smp_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_data;
  logic [3:0]  r_n_eff;
  logic [7:0]  r_N_eff;
  logic [7:0]  r_d;
  logic        r_str;
  logic        r_mode;
  logic        r_frame;
  logic        r_msg_ready;
  logic        r_configured;
  logic        r_busy;

  logic [3:0]  w_n_eff;
  logic [7:0]  w_N_eff;
  logic [19:0] w_cfg_word;
  logic        w_cfg_go;

  // Clamp the raw configuration inputs; the raw values are what go on the wire.
  always_comb begin
    w_cfg_word = {cfg_n, cfg_d, cfg_N};
    if ((cfg_n == 4'd0) || (cfg_n > 4'd8)) begin
      w_n_eff = 4'd8;
    end else begin
      w_n_eff = cfg_n;
    end
    if (cfg_N == 8'd0) begin
      w_N_eff = 8'd1;
    end else begin
      w_N_eff = cfg_N;
    end
    // A config request is only honoured when no frame is in flight.
    if ((r_state == S_IDLE) || (r_state == S_READY)) begin
      w_cfg_go = cfg_start;
    end else begin
      w_cfg_go = 1'b0;
    end
  end

  // Main FSM: sequences config shift, data samples and gap, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= 19'd0;
      r_cfg_cnt    <= 5'd0;
      r_smp_cnt    <= 8'd0;
      r_bit_cnt    <= 4'd0;
      r_gap_cnt    <= 8'd0;
      r_data       <= 8'd0;
      r_n_eff      <= 4'd8;
      r_N_eff      <= 8'd1;
      r_d          <= 8'd0;
      r_str        <= 1'b0;
      r_mode       <= 1'b0;
      r_frame      <= 1'b0;
      r_msg_ready  <= 1'b0;
      r_configured <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (w_cfg_go) begin
        // Config request wins over a simultaneous message in READY.
        r_state     <= S_CFG;
        r_n_eff     <= w_n_eff;
        r_N_eff     <= w_N_eff;
        r_d         <= cfg_d;
        r_str       <= w_cfg_word[19];
        r_shift     <= w_cfg_word[18:0];
        r_cfg_cnt   <= 5'd0;
        r_mode      <= 1'b1;
        r_busy      <= 1'b1;
        r_msg_ready <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_str       <= 1'b0;
            r_msg_ready <= 1'b0;
            r_busy      <= 1'b0;
          end
          S_CFG: begin
            if (r_cfg_cnt == 5'd19) begin
              r_state      <= S_READY;
              r_str        <= 1'b0;
              r_mode       <= 1'b0;
              r_busy       <= 1'b0;
              r_msg_ready  <= 1'b1;
              r_configured <= 1'b1;
            end else begin
              r_cfg_cnt <= r_cfg_cnt + 5'd1;
              r_str     <= r_shift[18];
              r_shift   <= {r_shift[17:0], 1'b0};
            end
          end
          S_READY: begin
            if (msg.msg_valid && r_msg_ready) begin
              r_state     <= S_DATA;
              r_str       <= msg.msg_data[7];
              r_data      <= {msg.msg_data[6:0], 1'b0};
              r_frame     <= 1'b1;
              r_smp_cnt   <= r_N_eff - 8'd1;
              r_bit_cnt   <= r_n_eff - 4'd1;
              r_msg_ready <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_str <= 1'b0;
            end
          end
          S_DATA: begin
            if (r_smp_cnt != 8'd0) begin
              r_smp_cnt <= r_smp_cnt - 8'd1;
            end else if (r_bit_cnt != 4'd0) begin
              // Bit boundary: the only place str may change inside a word.
              r_bit_cnt <= r_bit_cnt - 4'd1;
              r_smp_cnt <= r_N_eff - 8'd1;
              r_str     <= r_data[7];
              r_data    <= {r_data[6:0], 1'b0};
            end else if (r_d != 8'd0) begin
              r_state   <= S_GAP;
              r_str     <= 1'b0;
              r_gap_cnt <= r_d - 8'd1;
            end else begin
              r_state     <= S_READY;
              r_str       <= 1'b0;
              r_busy      <= 1'b0;
              r_msg_ready <= 1'b1;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == 8'd0) begin
              r_state     <= S_READY;
              r_busy      <= 1'b0;
              r_msg_ready <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt - 8'd1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_str       <= 1'b0;
            r_mode      <= 1'b0;
            r_busy      <= 1'b0;
            r_msg_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign str           = r_str;
  assign mode          = r_mode;
  assign frame         = r_frame;
  assign configured    = r_configured;
  assign busy          = r_busy;
  assign msg.msg_ready = r_msg_ready;

endmodule
